// File: rtl/digit_serial_adder_seq.sv
`default_nettype none
// ============================================================================
// Module   : digit_serial_adder_seq
// Purpose  : Sequential WIDTH-bit unsigned adder. Accepts an operand pair
//            through a valid/ready handshake, then drives an external
//            combinational 2-bit full-adder slice one digit per cycle,
//            LSB digit first. The carry between digits is kept in a register.
//            The full-width result is returned through a second valid/ready
//            handshake.
// Ports    : clk, rst                 - clock, synchronous active-high reset
//            in_valid_i / in_ready_o  - operand handshake
//            in_a_i, in_b_i, in_cin_i - operands and carry-in
//            out_valid_o/out_ready_i  - result handshake
//            out_sum_o, out_cout_o    - (a + b + cin) mod 2^WIDTH, carry-out
//            sl_a_o, sl_b_o, sl_cin_o - digit operands driven to the slice
//            sl_sum_i, sl_cout_i      - slice result (combinational)
// Revision : 1.0 - initial release
// ============================================================================
module digit_serial_adder_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_a_i,
  input  logic [WIDTH-1:0] in_b_i,
  input  logic             in_cin_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_sum_o,
  output logic             out_cout_o,
  output logic [1:0]       sl_a_o,
  output logic [1:0]       sl_b_o,
  output logic             sl_cin_o,
  input  logic [1:0]       sl_sum_i,
  input  logic             sl_cout_i
);

  localparam int D  = WIDTH / 2;
  localparam int KW = (D > 1) ? $clog2(D) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(D - 1);

  if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_bad_width
    $error("digit_serial_adder_seq: WIDTH must be even and >= 2");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              carry_q, carry_d;
  logic [KW-1:0]     k_q, k_d;
  logic [KW:0]       bit_idx;

  // Bit offset of the current digit: 2*k.
  assign bit_idx = {k_q, 1'b0};

  // The result registers double as the output holding registers, so the
  // last result stays visible after the handshake until the next accept.
  assign out_sum_o  = sum_q;
  assign out_cout_o = carry_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      k_q     <= k_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    carry_d     = carry_q;
    k_d         = k_q;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    sl_a_o      = 2'b00;
    sl_b_o      = 2'b00;
    sl_cin_o    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Held low while rst is asserted so no operand is taken during reset.
        in_ready_o = ~rst;
        if (in_valid_i && !rst) begin
          state_d = ST_RUN;
          a_d     = in_a_i;
          b_d     = in_b_i;
          carry_d = in_cin_i;
          sum_d   = '0;
          k_d     = '0;
        end
      end

      ST_RUN: begin
        sl_a_o   = a_q[bit_idx +: 2];
        sl_b_o   = b_q[bit_idx +: 2];
        sl_cin_o = carry_q;
        sum_d[bit_idx +: 2] = sl_sum_i;
        carry_d  = sl_cout_i;
        if (k_q == K_LAST) begin
          state_d = ST_DONE;
          k_d     = '0;
        end else begin
          k_d = k_q + 1'b1;
        end
      end

      ST_DONE: begin
        out_valid_o = 1'b1;
        if (out_ready_i) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire
